// File: rtl/fir_axis_tdm.sv
// Channel-interleaved AXI-Stream FIR with one time-shared multiplier and a runtime-loadable coefficient bank.
// Optional build macro FIR_ROUND_EN: round-half-up before saturation instead of truncation.
`timescale 1ns/1ps

module fir_axis_tdm #(
    parameter int AXI_BITWIDTH = 32,
    parameter int BITWIDTH     = 16,
    parameter int FRACT        = 15,
    parameter int TAPS         = 8,
    parameter int CHANNELS     = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
    input  logic signed [BITWIDTH-1:0] coef_wr_data,
    output logic                      coef_wr_ready,
    input  logic [AXI_BITWIDTH-1:0]   s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [AXI_BITWIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);
    // state | meaning
    // IDLE  | waiting for an input beat or a coefficient write
    // MAC   | one tap per cycle into the accumulator
    // OUT   | result presented, waiting for downstream ready
    localparam int TW = $clog2(TAPS);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW = 2 * BITWIDTH + TW;

    localparam logic signed [AW-1:0] RES_MAX = AW'((64'sd1 <<< (BITWIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] RES_MIN = AW'(-(64'sd1 <<< (BITWIDTH - 1)));
    localparam logic signed [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH - 1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state, state_nxt;

    logic                        run;
    logic [TW-1:0]               tap;
    logic [CW-1:0]               ch, cur_ch;
    logic                        tlast_q;
    logic signed [BITWIDTH-1:0]  coef  [TAPS];
    logic signed [BITWIDTH-1:0]  dline [CHANNELS][TAPS];
    logic signed [2*BITWIDTH-1:0] prod;
    logic signed [AW-1:0]        acc, acc_fin, acc_rnd, res;
    logic signed [BITWIDTH-1:0]  sat;
    logic                        in_fire, wr_fire, last_tap;
    logic                        unused_tdata;

    // run stays low through reset so the input is not offered until the first clock after release
    assign s_axis_tready = (state == IDLE) && run;
    assign coef_wr_ready = (state == IDLE);
    assign m_axis_tvalid = (state == OUT);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign wr_fire       = coef_wr_en && coef_wr_ready && (32'(coef_wr_addr) < TAPS);
    assign last_tap      = (tap == TW'(TAPS - 1));
    assign unused_tdata  = &{1'b0, s_axis_tdata};

    assign prod    = coef[tap] * dline[cur_ch][tap];
    assign acc_fin = acc + AW'(prod);
`ifdef FIR_ROUND_EN
    assign acc_rnd = acc_fin + (AW'(1) <<< (FRACT - 1));
`else
    assign acc_rnd = acc_fin;
`endif
    assign res = acc_rnd >>> FRACT;

    always_comb begin
        sat = res[BITWIDTH-1:0];
        if (res > RES_MAX)
            sat = SAT_MAX;
        else if (res < RES_MIN)
            sat = SAT_MIN;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_fire) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     if (m_axis_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            run          <= 1'b0;
            tap          <= '0;
            ch           <= '0;
            cur_ch       <= '0;
            tlast_q      <= 1'b0;
            acc          <= '0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            if (in_fire) begin
                cur_ch  <= ch;
                tlast_q <= s_axis_tlast;
                acc     <= '0;
                tap     <= '0;
                // a frame end restarts the interleave at channel 0
                ch      <= (s_axis_tlast || ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
            end else if (state == MAC) begin
                acc <= acc_fin;
                tap <= tap + 1'b1;
                if (last_tap) begin
                    m_axis_tdata <= AXI_BITWIDTH'(sat);
                    m_axis_tlast <= tlast_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    dline[c][k] <= '0;
            end
        end else begin
            if (wr_fire)
                coef[coef_wr_addr] <= coef_wr_data;
            if (in_fire) begin
                dline[ch][0] <= s_axis_tdata[BITWIDTH-1:0];
                for (int k = 1; k < TAPS; k++)
                    dline[ch][k] <= dline[ch][k-1];
            end
        end
    end
endmodule
